// File: rtl/hilo_mult_unit_if.sv
// hilo_mult_unit_if: command/result bundle between EX-stage control and the HI/LO multiply unit.
interface hilo_mult_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit: HI/LO owner; radix-2 shift-add MULT/MULTU/MADD/MSUB plus single-cycle MTHI/MTLO.
module hilo_mult_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic          clk,
    input logic          reset_n,
    hilo_mult_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MADD  = 3'd2;
    localparam logic [2:0] OP_MSUB  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, acc_q, prod, hilo, res;
    logic [WIDTH-1:0]     mplier_q, hi_q, lo_q, a_mag, b_mag;
    logic [CNT_W-1:0]     cnt_q;
    logic [2:0]           op_q;
    logic                 sign_q, done_q, accept, is_signed;
    // the iteration runs on magnitudes; the sign is reapplied once at FIN
    always_comb begin
        accept    = state_q == IDLE && bus.start && !bus.op[2];
        is_signed = bus.op != OP_MULTU;
        a_mag     = is_signed && bus.a[WIDTH-1] ? -bus.a : bus.a;
        b_mag     = is_signed && bus.b[WIDTH-1] ? -bus.b : bus.b;
        prod      = sign_q ? -acc_q : acc_q;
        hilo      = {hi_q, lo_q};
        res       = op_q == OP_MADD ? hilo + prod : op_q == OP_MSUB ? hilo - prod : prod;
        state_d   = state_q == IDLE ? (accept ? CALC : IDLE)
                  : state_q == CALC ? (cnt_q == CNT_W'(WIDTH - 1) ? FIN : CALC)
                  : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= state_q == FIN;
            if (state_q == IDLE && bus.start) begin
                if (accept) begin
                    mcand_q  <= {{WIDTH{1'b0}}, a_mag};
                    mplier_q <= b_mag;
                    sign_q   <= is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    op_q     <= bus.op;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                end else if (bus.op == OP_MTHI) hi_q <= bus.a;
                else if (bus.op == OP_MTLO) lo_q <= bus.a;
            end
            if (state_q == CALC) begin
                acc_q    <= mplier_q[0] ? acc_q + mcand_q : acc_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CNT_W'(1);
            end
            if (state_q == FIN) {hi_q, lo_q} <= res;
        end
    end
    assign bus.busy = state_q != IDLE;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
